// File: rtl/cosim_log_item_buffer.sv
// cosim_log_item_buffer
// Per-hart, per-kind FIFOs for cosim commit-log items. The DPI fetch pump pushes
// at most one item per cycle into a selected channel; each commit checker drains
// its own channel through an independent valid/ready pair. Heads are presented
// show-ahead, so an item pushed in cycle N is poppable in cycle N+1.
module cosim_log_item_buffer #(
  parameter int NUM_HARTS    = 1,
  parameter int NUM_KINDS    = 3,
  parameter int DPI_W        = 64,
  parameter int ITEM_WORDS   = 3,
  parameter int DEPTH        = 8,
  parameter bit DROP_ON_FULL = 1'b0,
  localparam int NCH = NUM_HARTS * NUM_KINDS,
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int IW  = ITEM_WORDS * DPI_W,
  localparam int OW  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_valid_i,
  output logic              push_ready_o,
  input  logic [CW-1:0]     push_chan_i,
  input  logic [IW-1:0]     push_data_i,
  output logic [NCH-1:0]    pop_valid_o,
  input  logic [NCH-1:0]    pop_ready_i,
  output logic [NCH*IW-1:0] pop_data_o,
  input  logic [NCH-1:0]    flush_i,
  output logic [NCH*OW-1:0] occupancy_o,
  output logic [NCH*16-1:0] drop_cnt_o,
  output logic              bad_chan_o
);

  localparam int PW   = $clog2(DEPTH);
  localparam int NSEL = 1 << CW;

  // blocked_ext covers every encodable channel number; codes beyond NCH stay 0
  // so an out-of-range push is always accepted (and then discarded).
  logic [NSEL-1:0] blocked_ext;
  logic [NCH-1:0]  sel_vec;
  logic            in_range;
  logic            push_fire;
  logic            bad_chan_reg;

  assign in_range   = |sel_vec;
  assign push_fire  = push_valid_i & push_ready_o;
  assign bad_chan_o = bad_chan_reg;

  // Push handshake: in drop mode the pump is never stalled.
  always_comb begin
    push_ready_o = 1'b1;
    if (!DROP_ON_FULL) begin
      push_ready_o = !blocked_ext[push_chan_i];
    end
  end

  // Sticky flag for pushes addressed to a channel that does not exist.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bad_chan_reg <= 1'b0;
    end else if (push_fire && !in_range) begin
      bad_chan_reg <= 1'b1;
    end
  end

  genvar gi;

  for (gi = NCH; gi < NSEL; gi++) begin : g_pad
    assign blocked_ext[gi] = 1'b0;
  end

  for (gi = 0; gi < NCH; gi++) begin : g_chan
    logic [IW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [OW-1:0] occ_reg, occ_next;
    logic [15:0]   drop_cnt_reg, drop_cnt_next;
    logic          full;
    logic          wr_en;
    logic          rd_en;
    logic          drop_en;

    assign full             = (occ_reg == OW'(DEPTH));
    assign sel_vec[gi]      = (push_chan_i == CW'(gi));
    // A full channel stays blocked even if its head is popped this cycle.
    assign blocked_ext[gi]  = full | flush_i[gi];
    assign wr_en   = push_fire & sel_vec[gi] & !full & !flush_i[gi];
    assign rd_en   = (occ_reg != '0) & pop_ready_i[gi];
    // Only reachable in drop mode: backpressure mode never accepts into a full channel.
    assign drop_en = push_fire & sel_vec[gi] & full & !flush_i[gi];

    // Pointer, occupancy and drop-counter update; flush overrides push and pop.
    always_comb begin
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      occ_next      = occ_reg;
      drop_cnt_next = drop_cnt_reg;
      if (flush_i[gi]) begin
        wr_ptr_next = '0;
        rd_ptr_next = '0;
        occ_next    = '0;
      end else begin
        if (wr_en) wr_ptr_next = wr_ptr_reg + PW'(1);
        if (rd_en) rd_ptr_next = rd_ptr_reg + PW'(1);
        case ({wr_en, rd_en})
          2'b10:   occ_next = occ_reg + OW'(1);
          2'b01:   occ_next = occ_reg - OW'(1);
          default: occ_next = occ_reg;
        endcase
      end
      if (drop_en && drop_cnt_reg != 16'hFFFF) begin
        drop_cnt_next = drop_cnt_reg + 16'd1;
      end
    end

    // Channel state registers, cleared immediately by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        occ_reg      <= '0;
        drop_cnt_reg <= '0;
      end else begin
        wr_ptr_reg   <= wr_ptr_next;
        rd_ptr_reg   <= rd_ptr_next;
        occ_reg      <= occ_next;
        drop_cnt_reg <= drop_cnt_next;
      end
    end

    // Item storage is never reset; it is only observed while occupancy is non-zero.
    always_ff @(posedge clk_i) begin
      if (wr_en) begin
        mem[wr_ptr_reg] <= push_data_i;
      end
    end

    assign pop_valid_o[gi]             = (occ_reg != '0);
    assign pop_data_o[gi*IW +: IW]     = mem[rd_ptr_reg];
    assign occupancy_o[gi*OW +: OW]    = occ_reg;
    assign drop_cnt_o[gi*16 +: 16]     = drop_cnt_reg;
  end

endmodule
